// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory bridge and future cache paths.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    localparam lc3b_word      ERR_RDATA_DEFAULT = 16'hDEAD;
    localparam lc3b_mem_wmask MASK_WORD         = 2'b11;

    // Physical memory is word addressed; the byte select lives in the write mask.
    function automatic lc3b_word word_align(input lc3b_word addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/lc3b_mem_bridge_if.sv
// CPU-side and physical-memory-side signals of the LC-3b memory bridge.
interface lc3b_mem_bridge_if;
    import lc3b_types::*;

    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_address;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;
    logic          mem_err;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_address;
    lc3b_word      pmem_wdata;
    lc3b_mem_wmask pmem_wmask;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    // Handshake: mem_read/mem_write are levels held by the CPU until the single
    // cycle mem_resp; pmem_read/pmem_write are held until pmem_resp is seen.
    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp, mem_err,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp, mem_err,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask
    );

endinterface

// File: rtl/lc3b_lane_steer.sv
// Byte-lane steering for stores: replicates the low byte and selects the lane by addr[0].
module lc3b_lane_steer
    import lc3b_types::*;
(
    input  logic          addr0,
    input  lc3b_mem_wmask mask,
    input  lc3b_word      wdata,
    output lc3b_mem_wmask steered_wmask,
    output lc3b_word      steered_wdata
);

    always_comb begin
        steered_wmask = MASK_WORD;
        steered_wdata = wdata;
        // Any mask other than a full word is a byte store of wdata[7:0].
        if (mask != MASK_WORD) begin
            steered_wmask = addr0 ? 2'b10 : 2'b01;
            steered_wdata = {wdata[7:0], wdata[7:0]};
        end
    end

endmodule

// File: rtl/lc3b_mem_bridge.sv
// Registers CPU memory requests onto the physical memory bus with a response watchdog.
module lc3b_mem_bridge
    import lc3b_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter lc3b_word    ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    lc3b_mem_bridge_if.slave   bus,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic          capture;
    logic          complete;
    logic          timeout;

    logic          op_write_q;
    lc3b_word      addr_q;
    lc3b_word      wdata_q;
    lc3b_mem_wmask wmask_q;
    lc3b_word      rdata_q;
    logic [15:0]   cnt_q;
    logic          err_q;

    lc3b_mem_wmask steer_wmask;
    lc3b_word      steer_wdata;

    lc3b_lane_steer u_lane_steer (
        .addr0         (bus.mem_address[0]),
        .mask          (bus.mem_byte_enable),
        .wdata         (bus.mem_wdata),
        .steered_wmask (steer_wmask),
        .steered_wdata (steer_wdata)
    );

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        complete = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    capture = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A response in the last allowed cycle still wins over the watchdog.
                if (bus.pmem_resp) begin
                    complete = 1'b1;
                    state_d  = S_RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Conflicting read+write is carried out as a write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else if (capture) begin
            op_write_q <= bus.mem_write;
            addr_q     <= word_align(bus.mem_address);
            wdata_q    <= steer_wdata;
            wmask_q    <= steer_wmask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            if (cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end else begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!op_write_q && complete) begin
                rdata_q <= bus.pmem_rdata;
            end else if (!op_write_q && timeout) begin
                rdata_q <= ERR_RDATA;
            end
            if (timeout || (capture && bus.mem_read && bus.mem_write)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.pmem_read    = (state_q == S_WAIT) && !op_write_q;
    assign bus.pmem_write   = (state_q == S_WAIT) &&  op_write_q;
    assign bus.pmem_address = addr_q;
    assign bus.pmem_wdata   = wdata_q;
    assign bus.pmem_wmask   = wmask_q;
    assign bus.mem_resp     = (state_q == S_RESP);
    assign bus.mem_rdata    = rdata_q;
    assign bus.mem_err      = err_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// Self-checking bench for lc3b_mem_bridge: vector table plus reset/timeout/abort sequences.
module tb_lc3b_mem_bridge;
  import lc3b_types::*;

  localparam int TO = 8;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] prdata;
    logic [15:0] exp_paddr;
    logic [15:0] exp_pwdata;
    logic [1:0]  exp_wmask;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int resp_cnt = 0;
  int txn_cnt = 0;
  logic prev_strobe = 1'b0;
  logic prev_resp = 1'b0;
  logic [15:0] exp_q[$];
  vec_t vecs[9];
  vec_t tvec;

  always #5 clk = ~clk;

  lc3b_mem_bridge_if bus();

  lc3b_mem_bridge #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(16'hDEAD)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] be,
                              input logic [15:0] addr, input logic [15:0] wdata, input int lat,
                              input logic [15:0] prdata, input logic [15:0] exp_paddr,
                              input logic [15:0] exp_pwdata, input logic [1:0] exp_wmask,
                              input logic [15:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.be = be; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.prdata = prdata; v.exp_paddr = exp_paddr; v.exp_pwdata = exp_pwdata;
    v.exp_wmask = exp_wmask; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  // Monitor: single-cycle mem_resp and transaction/response counts.
  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
      prev_resp = 1'b0;
    end else begin
      if (bus.mem_resp) begin
        resp_cnt++;
        check("resp_pulse", 32'(prev_resp), 32'd0);
      end
      if ((bus.pmem_read || bus.pmem_write) && !prev_strobe) txn_cnt++;
      prev_strobe = bus.pmem_read || bus.pmem_write;
      prev_resp = bus.mem_resp;
    end
  end

  // Starts at #1 after a posedge with the DUT idle; returns likewise, request still held.
  task automatic do_req(input vec_t v, input string tag);
    int strobes = 0;
    int resp_at = 0;
    logic saw_rd = 1'b0;
    logic saw_wr = 1'b0;
    int exp_lat = (v.lat != 0 && v.lat <= TO) ? v.lat : TO;
    logic [15:0] got_rdata;
    bus.mem_read = v.rd;
    bus.mem_write = v.wr;
    bus.mem_byte_enable = v.be;
    bus.mem_address = v.addr;
    bus.mem_wdata = v.wdata;
    exp_q.push_back(v.exp_rdata);
    for (int n = 1; n <= 40 && resp_at == 0; n++) begin
      @(posedge clk);
      #1;
      if (n >= 2) begin
        bus.mem_address = 16'($urandom);
        bus.mem_wdata = 16'($urandom);
        bus.mem_byte_enable = 2'($urandom_range(0, 3));
      end
      bus.pmem_resp = (v.lat != 0 && n == v.lat);
      bus.pmem_rdata = bus.pmem_resp ? v.prdata : 16'($urandom);
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        strobes++;
        saw_rd |= bus.pmem_read;
        saw_wr |= bus.pmem_write;
        check($sformatf("%s paddr", tag), 32'(bus.pmem_address), 32'(v.exp_paddr));
        if (v.wr) begin
          check($sformatf("%s pwdata", tag), 32'(bus.pmem_wdata), 32'(v.exp_pwdata));
          check($sformatf("%s pwmask", tag), 32'(bus.pmem_wmask), 32'(v.exp_wmask));
        end
      end
      if (bus.mem_resp) begin
        resp_at = n;
        got_rdata = bus.mem_rdata;
        check($sformatf("%s sb_depth", tag), 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check($sformatf("%s rdata", tag), 32'(got_rdata), 32'(exp_q.pop_front()));
      end
    end
    check($sformatf("%s resp_cycle", tag), resp_at, exp_lat + 1);
    check($sformatf("%s strobe_cycles", tag), strobes, exp_lat);
    check($sformatf("%s saw_pmem_write", tag), 32'(saw_wr), 32'(v.wr));
    check($sformatf("%s saw_pmem_read", tag), 32'(saw_rd), 32'(v.rd & ~v.wr));
    check($sformatf("%s mem_err", tag), 32'(bus.mem_err), 32'(v.exp_err));
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    //          rd wr be     addr     wdata    lat prdata   paddr    pwdata   wmask  rdata    err
    vecs[0] = mk(1, 0, 2'b11, 16'h3002, 16'h0000, 3, 16'h1234, 16'h3002, 16'h0000, 2'b11, 16'h1234, 0);
    vecs[1] = mk(0, 1, 2'b01, 16'h4001, 16'h00AB, 2, 16'h0000, 16'h4000, 16'hABAB, 2'b10, 16'h1234, 0);
    vecs[2] = mk(0, 1, 2'b10, 16'h4002, 16'h12CD, 1, 16'h0000, 16'h4002, 16'hCDCD, 2'b01, 16'h1234, 0);
    vecs[3] = mk(0, 1, 2'b11, 16'h5005, 16'hBEEF, 4, 16'h0000, 16'h5004, 16'hBEEF, 2'b11, 16'h1234, 0);
    vecs[4] = mk(1, 0, 2'b01, 16'h0007, 16'h0000, 1, 16'hA5A5, 16'h0006, 16'h0000, 2'b11, 16'hA5A5, 0);
    vecs[5] = mk(1, 0, 2'b11, 16'hFFFF, 16'h0000, 5, 16'h0F0F, 16'hFFFE, 16'h0000, 2'b11, 16'h0F0F, 0);
    vecs[6] = mk(0, 1, 2'b00, 16'h1233, 16'hFF77, 2, 16'h0000, 16'h1232, 16'h7777, 2'b10, 16'h0F0F, 0);
    vecs[7] = mk(1, 0, 2'b11, 16'h2000, 16'h0000, 8, 16'h7E57, 16'h2000, 16'h0000, 2'b11, 16'h7E57, 0);
    vecs[8] = mk(1, 1, 2'b11, 16'h6001, 16'h1111, 2, 16'h0000, 16'h6000, 16'h1111, 2'b11, 16'h7E57, 1);

    // Reset with a stale pmem_resp held high.
    rst = 1'b1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_address = 16'h0000;
    bus.mem_wdata = 16'h0000;
    bus.pmem_rdata = 16'hBAD1;
    bus.pmem_resp = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_resp", 32'(bus.mem_resp), 32'd0);
    check("rst mem_rdata", 32'(bus.mem_rdata), 32'd0);
    check("rst mem_err", 32'(bus.mem_err), 32'd0);
    check("rst pmem_read", 32'(bus.pmem_read), 32'd0);
    check("rst pmem_write", 32'(bus.pmem_write), 32'd0);
    check("rst pmem_address", 32'(bus.pmem_address), 32'd0);
    check("rst pmem_wdata", 32'(bus.pmem_wdata), 32'd0);
    check("rst pmem_wmask", 32'(bus.pmem_wmask), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("stale_resp mem_resp", 32'(bus.mem_resp), 32'd0);
      check("stale_resp mem_rdata", 32'(bus.mem_rdata), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b0;

    // Back-to-back vectors: each new request is presented in the IDLE cycle after RESP.
    for (int i = 0; i < 9; i++) do_req(vecs[i], $sformatf("vec%0d", i));
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;

    // Watchdog: memory never answers a read.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("pre_timeout mem_err", 32'(bus.mem_err), 32'd0);
    tvec = mk(1, 0, 2'b11, 16'h0ABC, 16'h0000, 0, 16'h0000, 16'h0ABC, 16'h0000, 2'b11, 16'hDEAD, 1);
    do_req(tvec, "timeout");
    bus.mem_read = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("timeout sticky mem_err", 32'(bus.mem_err), 32'd1);
      check("timeout hold rdata", 32'(bus.mem_rdata), 32'hDEAD);
      check("timeout idle state", 32'(dbg_state), 32'd0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset mid-WAIT, then a late pmem_resp.
    bus.mem_read = 1'b1;
    bus.mem_byte_enable = 2'b11;
    bus.mem_address = 16'h7000;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("abort strobe before rst", 32'(bus.pmem_read), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort pmem_read", 32'(bus.pmem_read), 32'd0);
    check("abort pmem_write", 32'(bus.pmem_write), 32'd0);
    check("abort state", 32'(dbg_state), 32'd0);
    check("abort mem_resp", 32'(bus.mem_resp), 32'd0);
    check("abort mem_err", 32'(bus.mem_err), 32'd0);
    bus.mem_read = 1'b0;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.pmem_resp = 1'b1;
    bus.pmem_rdata = 16'hBAD0;
    repeat (4) begin
      @(negedge clk);
      check("late_resp mem_resp", 32'(bus.mem_resp), 32'd0);
      check("late_resp state", 32'(dbg_state), 32'd0);
      check("late_resp mem_rdata", 32'(bus.mem_rdata), 32'd0);
      @(posedge clk);
      #1;
      bus.pmem_resp = 1'b0;
    end
    check("late_resp mem_err", 32'(bus.mem_err), 32'd0);

    check("sb empty", 32'(exp_q.size()), 32'd0);
    check("txn count", txn_cnt, 11);
    check("resp count", resp_cnt, 10);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
